uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and handshake sequencer directly upstream of `uart_tx`. Logger producers push bytes at full clock rate into a circular FIFO. The block issues them one at a time to `uart_tx` through its `din_rdy`/`din_byte` inputs and waits for each `tx_done` pulse before issuing the next byte. This decouples bursty sample formatting from the 9600-baud serial line.

## Interface

Parameters:
- `ADDR_W`, default 4: FIFO address width. Depth = 2^ADDR_W = 16 entries.

Ports:
- `clk`, input, 1: system clock, same domain as `uart_tx`.
- `reset`, input, 1: **synchronous, active-low** reset. Sampled on the rising edge of `clk`.
- `wr_en`, input, 1: push request for `wr_data`, one byte per cycle.
- `wr_data`, input, 8: byte to enqueue.
- `clr_ovf`, input, 1: clears `overflow`.
- `tx_done`, input, 1: one-cycle completion pulse from `uart_tx`.
- `din_rdy`, output, 1: one-cycle start pulse to `uart_tx`.
- `din_byte`, output, 8: byte to `uart_tx`. Registered and held stable until the next issue.
- `full`, output, 1: FIFO holds 2^ADDR_W entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `count`, output, ADDR_W+1: current number of stored entries, range 0..2^ADDR_W.
- `overflow`, output, 1: sticky flag, set when a write is dropped.
- `busy`, output, 1: high when a byte is in flight or the FIFO is not empty.

## Operation

- Storage is a 2^ADDR_W x 8 register array.
- `wr_ptr` and `rd_ptr` are ADDR_W bits wide and wrap modulo the depth.
- `count` is a separate ADDR_W+1-bit counter; `full` and `empty` decode from it.
- Write accepted: `wr_en`=1 and `full`=0. Store at `wr_ptr`, then increment `wr_ptr`.
- Write while full: the write is dropped. Memory and pointers are unchanged, and `overflow` is set to 1.
- `overflow` clears only on `clr_ovf`=1 or reset. If `clr_ovf` and a dropped write occur in the same cycle, set wins.
- Pop occurs only in the ISSUE transition (see below).
  - Push and pop in the same cycle: `count` unchanged, both pointers advance.
  - A push is legal at `count`=2^ADDR_W only if a pop occurs in the same cycle. Otherwise it counts as full and is dropped.
- State machine (registered):
  - IDLE: `din_rdy`=0. If `empty`=0, then on the next edge: `din_byte` <= mem[`rd_ptr`], `rd_ptr`++, `din_rdy` <= 1, go to BUSY. Otherwise stay in IDLE.
  - BUSY: `din_rdy` <= 0 (so the pulse is exactly one cycle). Hold `din_byte`. If `tx_done`=1, go to GAP.
  - GAP: one idle cycle, so `uart_tx` has left its Stop state and re-entered Start. Then go to IDLE.
- `tx_done` in IDLE or GAP is ignored.
- `busy` = (state != IDLE) | ~`empty`.
- Reset (`reset`=0 at an edge), including mid-transfer:
  - state=IDLE, pointers=0, `count`=0.
  - `din_rdy`=0, `din_byte`=8'h00.
  - `full`=0, `empty`=1, `overflow`=0, `busy`=0.
  - Memory contents are don't-care.
  - A byte already started in `uart_tx` is abandoned by this block.

## Timing

- Write to an empty FIFO while in IDLE:
  - edge k: write captured, `empty`=0 after edge k.
  - edge k+1: `din_rdy`=1 and `din_byte` valid. Latency is 2 cycles from `wr_en` to `din_rdy` visible.
- `din_byte` is stable from the `din_rdy` cycle until the next ISSUE. This satisfies `uart_tx` loading the byte one cycle after sampling `din_rdy`.
- Back-to-back issues: `tx_done` high in cycle t, GAP in cycle t+1, IDLE in cycle t+2, next `din_rdy` high in cycle t+3.
- `full`, `empty` and `count` update on the edge that performs the push or pop. They are never combinational from `wr_en`.

## Test plan

- Reset, then write 8'hA5: `din_rdy` is one-cycle high 2 cycles later with `din_byte`=8'hA5, and `busy`=1. Model `tx_done` 50 cycles later: `busy`=0 three cycles after it, no further `din_rdy`.
- Burst-write 16 bytes 8'h00..8'h0F while `tx_done` is withheld: `count` tops at 15 after the first pop. Issued order and values are 8'h00..8'h0F in sequence, with exactly 3 cycles from each `tx_done` to the next `din_rdy`.
- Write 17 bytes with `tx_done` held low: `full`=1 at `count`=16 (less one popped). Extra writes are dropped and `overflow`=1. Pulse `clr_ovf`: `overflow`=0. Same-cycle `clr_ovf` and dropped write: `overflow` stays 1.
- Write 40 bytes, each accepted only when `full`=0, against a `uart_tx` model: pointers wrap twice, output stream equals input stream, no losses.
- Assert `reset`=0 while in BUSY with `count`=5: next cycle `count`=0, `empty`=1, `din_byte`=8'h00. A later `tx_done` produces no `din_rdy`.
- Stray `tx_done` pulse in IDLE with an empty FIFO: no state change, no `din_rdy`.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO in front of uart_tx. Bytes are issued one
// at a time with a one-cycle din_rdy pulse; the next issue waits for tx_done.
module uart_tx_fifo #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   input  logic              clr_ovf,
   input  logic              tx_done,
   output logic              din_rdy,
   output logic [7:0]        din_byte,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              busy
);

   localparam int                DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_GAP
   } state_e;

   state_e              state_q, state_d;
   logic [7:0]          mem_q [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic                din_rdy_q, din_rdy_d;
   logic [7:0]          din_byte_q, din_byte_d;
   logic                overflow_q, overflow_d;
   logic                pop, push, drop;

   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // A pop frees a slot on the same edge, so a push at full is legal then.
   assign pop  = (state_q == ST_IDLE) && !empty;
   assign push = wr_en && (!full || pop);
   assign drop = wr_en && !push;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      din_rdy_d  = 1'b0;
      din_byte_d = din_byte_q;
      rd_ptr_d   = rd_ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               din_byte_d = mem_q[rd_ptr_q];
               rd_ptr_d   = rd_ptr_q + 1'b1;
               din_rdy_d  = 1'b1;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (tx_done) state_d = ST_GAP;
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      overflow_d = overflow_q;
      if (drop)         overflow_d = 1'b1;
      else if (clr_ovf) overflow_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         din_rdy_q  <= 1'b0;
         din_byte_q <= 8'h00;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         din_rdy_q  <= din_rdy_d;
         din_byte_q <= din_byte_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: storage is deliberately not reset; count gates every read, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign din_rdy  = din_rdy_q;
   assign din_byte = din_byte_q;
   assign count    = count_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != ST_IDLE) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed corner-case
// sequences and a randomized run against a queue-based uart_tx model.
module tb_uart_tx_fifo;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              wr_en = 1'b0;
   logic [7:0]        wr_data = 8'h00;
   logic              clr_ovf = 1'b0;
   logic              tx_done = 1'b0;
   logic              din_rdy;
   logic [7:0]        din_byte;
   logic              full, empty, overflow, busy;
   logic [ADDR_W:0]   count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_bytes [$];

   always #5 clk = ~clk;

   uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .clr_ovf  (clr_ovf),
      .tx_done  (tx_done),
      .din_rdy  (din_rdy),
      .din_byte (din_byte),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .busy     (busy)
   );

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_data;
      logic       clr_ovf;
      logic       tx_done;
      logic       exp_rdy;
      logic [7:0] exp_byte;
      logic [4:0] exp_count;
      logic       exp_busy;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_en   = 1'b0;
      clr_ovf = 1'b0;
      tx_done = 1'b0;
      reset   = 1'b0;
      repeat (2) tick();
      reset   = 1'b1;
   endtask

   task automatic wait_rdy(input int limit, output int cyc);
      cyc = 0;
      while (!din_rdy && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   task automatic pulse_done();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   // Expects a byte already in flight; completes it and every queued byte.
   task automatic drain(input string tag);
      int cyc;
      while (exp_bytes.size() > 0) begin
         repeat (2) tick();
         pulse_done();
         wait_rdy(20, cyc);
         check({tag, "_rdy"}, din_rdy, 1);
         check({tag, "_gap"}, 1 + cyc, 3);
         check({tag, "_byte"}, din_byte, exp_bytes.pop_front());
      end
      repeat (2) tick();
      pulse_done();
      wait_rdy(10, cyc);
      check({tag, "_no_extra"}, din_rdy, 0);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      int max_cnt;

      vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
      vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 5'd0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 5'd0, 1'b1, 1'b0};

      // Reset state
      do_reset();
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 0);
      check("rst_rdy", din_rdy, 0);
      check("rst_byte", din_byte, 8'h00);

      // Vector table, one cycle per row
      for (int i = 0; i < 14; i++) begin
         wr_en   = vecs[i].wr_en;
         wr_data = vecs[i].wr_data;
         clr_ovf = vecs[i].clr_ovf;
         tx_done = vecs[i].tx_done;
         tick();
         check($sformatf("vec%0d_rdy", i), din_rdy, vecs[i].exp_rdy);
         check($sformatf("vec%0d_byte", i), din_byte, vecs[i].exp_byte);
         check($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
         check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_count == 0);
         check($sformatf("vec%0d_full", i), full, vecs[i].exp_count == 5'd16);
         check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
         check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
      end
      wr_en = 1'b0; clr_ovf = 1'b0; tx_done = 1'b0;

      // Single byte: latency, one-cycle pulse, busy drop after tx_done
      do_reset();
      wr_en = 1'b1; wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      check("a5_not_early", din_rdy, 0);
      tick();
      check("a5_rdy", din_rdy, 1);
      check("a5_byte", din_byte, 8'hA5);
      check("a5_busy", busy, 1);
      tick();
      check("a5_pulse_len", din_rdy, 0);
      repeat (50) tick();
      check("a5_byte_held", din_byte, 8'hA5);
      pulse_done();
      repeat (2) tick();
      check("a5_busy_off", busy, 0);
      wait_rdy(10, cyc);
      check("a5_no_extra", din_rdy, 0);

      // Burst of 16 with tx_done withheld
      do_reset();
      max_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wr_data = 8'(i);
         tick();
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      wr_en = 1'b0;
      check("burst_max_count", max_cnt, 15);
      check("burst_first_byte", din_byte, 8'h00);
      for (int i = 1; i < 16; i++) exp_bytes.push_back(8'(i));
      drain("burst");

      // Overflow, clear, same-cycle set-wins, push-with-pop at full
      do_reset();
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h20 + i);
         tick();
      end
      check("ovf_full", full, 1);
      check("ovf_count16", count, 16);
      check("ovf_not_yet", overflow, 0);
      wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      check("ovf_set", overflow, 1);
      check("ovf_count_kept", count, 16);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      check("ovf_cleared", overflow, 0);
      wr_en = 1'b1; clr_ovf = 1'b1; wr_data = 8'hFE;
      tick();
      wr_en = 1'b0; clr_ovf = 1'b0;
      check("ovf_set_wins", overflow, 1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      pulse_done();
      tick();
      check("pushpop_full_before", full, 1);
      wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      wr_en = 1'b0;
      check("pushpop_count", count, 16);
      check("pushpop_rdy", din_rdy, 1);
      check("pushpop_byte", din_byte, 8'h21);
      check("pushpop_no_ovf", overflow, 0);
      for (int i = 2; i < 17; i++) exp_bytes.push_back(8'(8'h20 + i));
      exp_bytes.push_back(8'hEE);
      drain("ovf");

      // Randomized 40-byte stream against a uart_tx model
      do_reset();
      begin
         int sent, got, model_cnt, hold;
         bit in_flight;
         sent = 0; got = 0; model_cnt = 0; hold = 0; in_flight = 1'b0;
         exp_bytes.delete();
         for (int c = 0; c < 4000 && got < 40; c++) begin
            wr_en   = (sent < 40) && !full && ($urandom_range(0, 1) == 1);
            wr_data = 8'($urandom_range(0, 255));
            tx_done = 1'b0;
            if (in_flight) begin
               if (hold == 0) begin
                  tx_done   = 1'b1;
                  in_flight = 1'b0;
               end else hold--;
            end
            if (wr_en) begin
               exp_bytes.push_back(wr_data);
               sent++;
               model_cnt++;
            end
            tick();
            if (din_rdy) begin
               check("rand_rdy_while_inflight", in_flight, 0);
               if (exp_bytes.size() > 0) check("rand_byte", din_byte, exp_bytes.pop_front());
               else check("rand_unexpected_rdy", 1, 0);
               got++;
               model_cnt--;
               in_flight = 1'b1;
               hold = $urandom_range(0, 8);
            end
            if (int'(count) != model_cnt) check($sformatf("rand_count_c%0d", c), count, model_cnt);
            if (full != (model_cnt == DEPTH)) check($sformatf("rand_full_c%0d", c), full, model_cnt == DEPTH);
         end
         wr_en = 1'b0; tx_done = 1'b0;
         check("rand_all_sent", sent, 40);
         check("rand_all_received", got, 40);
         check("rand_final_count", count, 0);
         check("rand_no_ovf", overflow, 0);
      end

      // Reset during BUSY with five entries queued
      do_reset();
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_data = 8'(8'h70 + i);
         tick();
      end
      wr_en = 1'b0;
      check("midrst_count5", count, 5);
      check("midrst_busy_pre", busy, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("midrst_count", count, 0);
      check("midrst_empty", empty, 1);
      check("midrst_byte", din_byte, 8'h00);
      check("midrst_rdy", din_rdy, 0);
      check("midrst_busy", busy, 0);
      pulse_done();
      wait_rdy(10, cyc);
      check("midrst_no_rdy", din_rdy, 0);

      // Stray tx_done in IDLE with an empty FIFO
      pulse_done();
      check("stray_rdy", din_rdy, 0);
      check("stray_busy", busy, 0);
      wait_rdy(5, cyc);
      check("stray_no_rdy", din_rdy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
